// File: rtl/alu_unit_pkg.sv
// Shared constants and types for the ALU unit: ROB tag width, funct3 opcodes,
// the default result-queue depth and the queue entry layout.
package alu_unit_pkg;

  localparam int unsigned ROB_SIZE_WIDTH      = 4;
  localparam int unsigned ALU_Q_DEPTH_DEFAULT = 4;
  localparam int unsigned ALU_Q_WIDTH_DEFAULT = 2;

  // funct3 encodings; funct7[5] selects sub/sra within OpAddSub/OpSrlSra
  typedef enum logic [2:0] {
    OpAddSub = 3'b000,
    OpSll    = 3'b001,
    OpSlt    = 3'b010,
    OpSltu   = 3'b011,
    OpXor    = 3'b100,
    OpSrlSra = 3'b101,
    OpOr     = 3'b110,
    OpAnd    = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0]               value;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result queue for the ALU: in-order FIFO with push, pop, synchronous flush
// and a global stall (rdy_i low holds everything). Storage is not reset.
module alu_result_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  parameter int unsigned DataW = 36
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] head_o,
  output logic [Width:0]   count_o,
  output logic             empty_o
);

  localparam int unsigned CountW = Width + 1;
  localparam logic [Width:0] DepthC = CountW'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [Width-1:0] wr_ptr_q, wr_ptr_d;
  logic [Width-1:0] rd_ptr_q, rd_ptr_d;
  logic [Width:0]   count_q, count_d;
  logic             push_fire, pop_fire;

  // Qualify push/pop; a push into a completely full queue is dropped unless a pop frees a slot.
  always_comb begin
    pop_fire  = rdy_i && !flush_i && pop_i && (count_q != '0);
    push_fire = rdy_i && !flush_i && push_i && ((count_q != DepthC) || pop_fire);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (rdy_i && flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + Width'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + Width'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CountW'(1);
        2'b01:   count_d = count_q - CountW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

`ifndef SYNTHESIS
  // The RS must respect alu_full; reaching this means an issue was lost.
  overflow_push_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(rdy_i && !flush_i && push_i && !pop_fire && (count_q == DepthC)));
`endif

endmodule

// File: rtl/alu_unit.sv
// Integer ALU for the out-of-order core: computes the RV32I register ops and
// queues {result, rob_id} for broadcast on the CDB.
// Optional macro ALU_BYPASS_EN: when the queue is empty, an issue is presented
// on the outputs in the same cycle and skips the queue if the CDB grants it.
module alu_unit import alu_unit_pkg::*; #(
  parameter int unsigned ALU_Q_DEPTH = ALU_Q_DEPTH_DEFAULT,
  parameter int unsigned ALU_Q_WIDTH = ALU_Q_WIDTH_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      rs_ready,
  input  logic [2:0]                rs_op_L1,
  input  logic                      rs_op_L2,
  input  logic [31:0]               rs_opr1,
  input  logic [31:0]               rs_opr2,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  input  logic                      cdb_grant_in,
  output logic                      alu_valid,
  output logic [31:0]               alu_value,
  output logic [ROB_SIZE_WIDTH-1:0] alu_dependency,
  output logic                      alu_full
);

  localparam int unsigned CountW = ALU_Q_WIDTH + 1;

  logic [31:0]       result;
  logic [4:0]        shamt;
  logic              issue_fire;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_valid;
  logic [CountW-1:0] fifo_count;
  alu_entry_t        fifo_head, issue_entry;

  // Combinational compute of the issued operation.
  always_comb begin
    result = '0;
    shamt  = rs_opr2[4:0];
    unique case (alu_op_e'(rs_op_L1))
      OpAddSub: result = rs_op_L2 ? (rs_opr1 - rs_opr2) : (rs_opr1 + rs_opr2);
      OpSll:    result = rs_opr1 << shamt;
      OpSlt:    result = {31'b0, $signed(rs_opr1) < $signed(rs_opr2)};
      OpSltu:   result = {31'b0, rs_opr1 < rs_opr2};
      OpXor:    result = rs_opr1 ^ rs_opr2;
      OpSrlSra: result = rs_op_L2 ? $unsigned($signed(rs_opr1) >>> shamt) : (rs_opr1 >> shamt);
      OpOr:     result = rs_opr1 | rs_opr2;
      OpAnd:    result = rs_opr1 & rs_opr2;
    endcase
  end

  assign issue_entry = '{value: result, rob_id: rs_rob_id};
  assign issue_fire  = rs_ready && rdy_in && !need_flush_in;
  assign fifo_valid  = !fifo_empty;
  assign fifo_pop    = fifo_valid && cdb_grant_in;

`ifdef ALU_BYPASS_EN
  logic bypass;
  // Reset gates the bypass so outputs stay quiet while rst_in is high.
  assign bypass    = fifo_empty && issue_fire && !rst_in;
  assign fifo_push = issue_fire && !(bypass && cdb_grant_in);
`else
  assign fifo_push = issue_fire;
`endif

  // Broadcast: queue head, or the live issue when bypassing an empty queue.
  always_comb begin
    alu_valid      = fifo_valid;
    alu_value      = fifo_valid ? fifo_head.value : '0;
    alu_dependency = fifo_valid ? fifo_head.rob_id : '0;
`ifdef ALU_BYPASS_EN
    if (bypass) begin
      alu_valid      = 1'b1;
      alu_value      = result;
      alu_dependency = rs_rob_id;
    end
`endif
  end

  // One slot of slack covers the RS's registered issue decision.
  assign alu_full = (fifo_count >= CountW'(ALU_Q_DEPTH - 1));

  alu_result_fifo #(
    .Depth (ALU_Q_DEPTH),
    .Width (ALU_Q_WIDTH),
    .DataW ($bits(alu_entry_t))
  ) u_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .rdy_i       (rdy_in),
    .flush_i     (need_flush_in),
    .push_i      (fifo_push),
    .push_data_i (issue_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule
